// File: rtl/bus_cycle_sequencer_if.sv
// Control-unit request/response and external i8080 bus signals of the machine-cycle sequencer.
// slave = sequencer side; master = control unit plus external bus/memory side.
interface bus_cycle_sequencer_if #(
   parameter int XLEN = 8
);
   logic                start;
   logic [2:0]          cycle_type;
   logic [2*XLEN-1:0]   addr_in;
   logic [XLEN-1:0]     wdata_in;
   logic                post_inc;
   logic                accept;
   logic                done;
   logic [XLEN-1:0]     rdata_out;
   logic                inc_req;
   logic [2*XLEN-1:0]   addr;
   logic [XLEN-1:0]     dout;
   logic                dout_en;
   logic [XLEN-1:0]     din;
   logic                sync;
   logic                dbin;
   logic                wr_n;
   logic                ready;

   modport slave (
      input  start, cycle_type, addr_in, wdata_in, post_inc, din, ready,
      output accept, done, rdata_out, inc_req, addr, dout, dout_en, sync, dbin, wr_n
   );

   modport master (
      output start, cycle_type, addr_in, wdata_in, post_inc, din, ready,
      input  accept, done, rdata_out, inc_req, addr, dout, dout_en, sync, dbin, wr_n
   );
endinterface

// File: rtl/bus_cycle_sequencer.sv
// Runs one i8080 machine cycle (T1, T2, TW*, T3) per accepted request; done in T3, 3 cycles + waits.
// Requests are taken only in IDLE or T3 (accept); external ready low stretches the cycle with TW states.
module bus_cycle_sequencer #(
   parameter int XLEN = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   bus_cycle_sequencer_if.slave  bus
);
   typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3} state_e;

   localparam logic [2:0] CT_FETCH    = 3'd0;
   localparam logic [2:0] CT_MEM_RD   = 3'd1;
   localparam logic [2:0] CT_MEM_WR   = 3'd2;
   localparam logic [2:0] CT_STACK_RD = 3'd3;
   localparam logic [2:0] CT_STACK_WR = 3'd4;
   localparam logic [2:0] CT_IO_RD    = 3'd5;
   localparam logic [2:0] CT_IO_WR    = 3'd6;

   state_e              state_q, state_d;
   logic [2:0]          type_q;
   logic [2*XLEN-1:0]   addr_q;
   logic [XLEN-1:0]     wdata_q;
   logic                inc_q;
   logic [XLEN-1:0]     rdata_q, rdata_d;
   logic                take;

   logic                is_wr, is_io;
   logic [XLEN-1:0]     status;
   logic                accept, done, inc_req, sync, dbin, wr_n, dout_en;
   logic [XLEN-1:0]     dout;

   always_comb begin
      is_wr = (type_q == CT_MEM_WR) || (type_q == CT_STACK_WR) || (type_q == CT_IO_WR);
      is_io = (type_q == CT_IO_RD) || (type_q == CT_IO_WR);
      case (type_q)
         CT_FETCH:    status = XLEN'(8'hA2);
         CT_MEM_RD:   status = XLEN'(8'h82);
         CT_MEM_WR:   status = XLEN'(8'h00);
         CT_STACK_RD: status = XLEN'(8'h86);
         CT_STACK_WR: status = XLEN'(8'h04);
         CT_IO_RD:    status = XLEN'(8'h42);
         CT_IO_WR:    status = XLEN'(8'h10);
         default:     status = XLEN'(8'h23);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         type_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         inc_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         if (take) begin
            type_q  <= bus.cycle_type;
            addr_q  <= bus.addr_in;
            wdata_q <= bus.wdata_in;
            inc_q   <= bus.post_inc;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
      take    = 1'b0;
      accept  = 1'b0;
      done    = 1'b0;
      inc_req = 1'b0;
      sync    = 1'b0;
      dbin    = 1'b0;
      wr_n    = 1'b1;
      dout_en = 1'b0;
      dout    = '0;
      case (state_q)
         S_IDLE: begin
            accept = 1'b1;
            if (bus.start) begin
               take    = 1'b1;
               state_d = S_T1;
            end
         end
         S_T1: begin
            sync    = 1'b1;
            dout_en = 1'b1;
            dout    = status;
            state_d = S_T2;
         end
         S_T2, S_TW: begin
            if (is_wr) begin
               dout    = wdata_q;
               dout_en = 1'b1;
            end else begin
               dbin = 1'b1;
            end
            // Post-increment request fires once, in T2 only, never repeated by wait states.
            inc_req = (state_q == S_T2) && inc_q;
            state_d = bus.ready ? S_T3 : S_TW;
         end
         S_T3: begin
            accept = 1'b1;
            done   = 1'b1;
            if (is_wr) begin
               wr_n    = 1'b0;
               dout    = wdata_q;
               dout_en = 1'b1;
            end else begin
               dbin    = 1'b1;
               rdata_d = bus.din;
            end
            take    = bus.start;
            state_d = bus.start ? S_T1 : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // I/O cycles place the 8-bit port number on both address halves.
   assign bus.addr      = is_io ? {addr_q[XLEN-1:0], addr_q[XLEN-1:0]} : addr_q;
   assign bus.accept    = accept;
   assign bus.done      = done;
   assign bus.inc_req   = inc_req;
   assign bus.sync      = sync;
   assign bus.dbin      = dbin;
   assign bus.wr_n      = wr_n;
   assign bus.dout_en   = dout_en;
   assign bus.dout      = dout;
   assign bus.rdata_out = rdata_q;
endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Directed self-checking bench for bus_cycle_sequencer: one task per scenario, checks at negedge.
module tb_bus_cycle_sequencer;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   bus_cycle_sequencer_if #(.XLEN(8)) bif ();

   bus_cycle_sequencer #(.XLEN(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   // {accept, done, inc_req, sync, dbin, wr_n, dout_en}
   logic [6:0] ctl;
   assign ctl = {bif.accept, bif.done, bif.inc_req, bif.sync, bif.dbin, bif.wr_n, bif.dout_en};

   localparam logic [6:0] C_IDLE   = 7'b1000010;
   localparam logic [6:0] C_T1     = 7'b0001011;
   localparam logic [6:0] C_RD_INC = 7'b0010110;
   localparam logic [6:0] C_RD     = 7'b0000110;
   localparam logic [6:0] C_WR     = 7'b0000011;
   localparam logic [6:0] C_T3_RD  = 7'b1100110;
   localparam logic [6:0] C_T3_WR  = 7'b1100001;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic issue(input logic [2:0] t, input logic [15:0] a, input logic [7:0] w,
                        input logic inc);
      bif.start      = 1'b1;
      bif.cycle_type = t;
      bif.addr_in    = a;
      bif.wdata_in   = w;
      bif.post_inc   = inc;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (ctl !== C_IDLE) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_IDLE); end
      checks++; if ({bif.addr, bif.dout, bif.rdata_out} !== 32'h0) begin failures++;
         $display("FAIL reset_data got addr=%h dout=%h rdata=%h exp all zero", bif.addr, bif.dout, bif.rdata_out); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_fetch();
      bif.din = 8'h3E; bif.ready = 1'b1;
      issue(3'd0, 16'h1234, 8'h00, 1'b1);
      tick();  // T1
      bif.start = 1'b0; bif.addr_in = 16'hFFFF;
      checks++; if (ctl !== C_T1) begin failures++; $display("FAIL fetch_t1_ctl got=%b exp=%b", ctl, C_T1); end
      checks++; if ({bif.addr, bif.dout} !== 24'h1234A2) begin failures++;
         $display("FAIL fetch_t1_bus got addr=%h dout=%h exp addr=1234 dout=a2", bif.addr, bif.dout); end
      tick();  // T2
      checks++; if (ctl !== C_RD_INC) begin failures++; $display("FAIL fetch_t2_ctl got=%b exp=%b", ctl, C_RD_INC); end
      tick();  // T3
      checks++; if (ctl !== C_T3_RD) begin failures++; $display("FAIL fetch_t3_ctl got=%b exp=%b", ctl, C_T3_RD); end
      checks++; if (bif.addr !== 16'h1234) begin failures++; $display("FAIL fetch_t3_addr got=%h exp=1234", bif.addr); end
      tick();  // IDLE
      checks++; if (ctl !== C_IDLE) begin failures++; $display("FAIL fetch_idle_ctl got=%b exp=%b", ctl, C_IDLE); end
      checks++; if (bif.rdata_out !== 8'h3E) begin failures++; $display("FAIL fetch_rdata got=%h exp=3e", bif.rdata_out); end
      checks++; if (bif.addr !== 16'h1234) begin failures++; $display("FAIL fetch_addr_hold got=%h exp=1234", bif.addr); end
   endtask

   task automatic test_mem_wr_wait();
      bif.ready = 1'b0; bif.din = 8'hEE;
      issue(3'd2, 16'h2000, 8'h5A, 1'b0);
      tick();  // T1
      bif.start = 1'b0;
      checks++; if ({ctl, bif.dout} !== {C_T1, 8'h00}) begin failures++;
         $display("FAIL memwr_t1 got ctl=%b dout=%h exp ctl=%b dout=00", ctl, bif.dout, C_T1); end
      tick();  // T2
      checks++; if ({ctl, bif.dout} !== {C_WR, 8'h5A}) begin failures++;
         $display("FAIL memwr_t2 got ctl=%b dout=%h exp ctl=%b dout=5a", ctl, bif.dout, C_WR); end
      tick();  // TW1
      checks++; if (ctl !== C_WR) begin failures++; $display("FAIL memwr_tw1 got=%b exp=%b", ctl, C_WR); end
      tick();  // TW2
      bif.ready = 1'b1;
      checks++; if (ctl !== C_WR) begin failures++; $display("FAIL memwr_tw2 got=%b exp=%b", ctl, C_WR); end
      tick();  // T3 on the 5th cycle
      checks++; if ({ctl, bif.dout, bif.addr} !== {C_T3_WR, 8'h5A, 16'h2000}) begin failures++;
         $display("FAIL memwr_t3 got ctl=%b dout=%h addr=%h exp ctl=%b dout=5a addr=2000", ctl, bif.dout, bif.addr, C_T3_WR); end
      tick();
      checks++; if ({ctl, bif.rdata_out} !== {C_IDLE, 8'h3E}) begin failures++;
         $display("FAIL memwr_idle got ctl=%b rdata=%h exp ctl=%b rdata=3e", ctl, bif.rdata_out, C_IDLE); end
   endtask

   task automatic test_io();
      bif.din = 8'hC3; bif.ready = 1'b1;
      issue(3'd5, 16'h0707, 8'h00, 1'b0);
      tick();  // T1
      bif.start = 1'b0;
      checks++; if ({bif.addr, bif.dout} !== 24'h070742) begin failures++;
         $display("FAIL iord_t1 got addr=%h dout=%h exp addr=0707 dout=42", bif.addr, bif.dout); end
      tick();  // T2
      checks++; if (ctl !== C_RD) begin failures++; $display("FAIL iord_t2_ctl got=%b exp=%b", ctl, C_RD); end
      tick();  // T3
      tick();
      checks++; if (bif.rdata_out !== 8'hC3) begin failures++; $display("FAIL iord_rdata got=%h exp=c3", bif.rdata_out); end
      issue(3'd6, 16'h0010, 8'h77, 1'b0);
      tick();  // T1
      bif.start = 1'b0;
      checks++; if ({bif.addr, bif.dout} !== 24'h101010) begin failures++;
         $display("FAIL iowr_t1 got addr=%h dout=%h exp addr=1010 dout=10", bif.addr, bif.dout); end
      tick();  // T2
      tick();  // T3
      checks++; if ({ctl, bif.dout, bif.addr} !== {C_T3_WR, 8'h77, 16'h1010}) begin failures++;
         $display("FAIL iowr_t3 got ctl=%b dout=%h addr=%h exp ctl=%b dout=77 addr=1010", ctl, bif.dout, bif.addr, C_T3_WR); end
      tick();
   endtask

   task automatic test_back_to_back();
      bif.din = 8'h99; bif.ready = 1'b1;
      issue(3'd3, 16'h3000, 8'h00, 1'b1);
      tick();  // T1
      bif.start = 1'b0;
      checks++; if (bif.dout !== 8'h86) begin failures++; $display("FAIL b2b_stackrd_status got=%h exp=86", bif.dout); end
      tick();  // T2
      tick();  // T3
      checks++; if (ctl !== C_T3_RD) begin failures++; $display("FAIL b2b_t3_ctl got=%b exp=%b", ctl, C_T3_RD); end
      issue(3'd4, 16'h4000, 8'h11, 1'b0);
      tick();  // T1 of second cycle, no IDLE gap
      bif.start = 1'b0;
      checks++; if ({ctl, bif.dout, bif.addr} !== {C_T1, 8'h04, 16'h4000}) begin failures++;
         $display("FAIL b2b_t1 got ctl=%b dout=%h addr=%h exp ctl=%b dout=04 addr=4000", ctl, bif.dout, bif.addr, C_T1); end
      checks++; if (bif.rdata_out !== 8'h99) begin failures++; $display("FAIL b2b_rdata got=%h exp=99", bif.rdata_out); end
      tick();  // T2
      checks++; if ({ctl, bif.dout} !== {C_WR, 8'h11}) begin failures++;
         $display("FAIL b2b_t2 got ctl=%b dout=%h exp ctl=%b dout=11", ctl, bif.dout, C_WR); end
      tick();  // T3
      checks++; if (ctl !== C_T3_WR) begin failures++; $display("FAIL b2b_t3_wr got=%b exp=%b", ctl, C_T3_WR); end
      tick();
   endtask

   task automatic test_reset_mid();
      int seen_done;
      seen_done = 0;
      bif.din = 8'hAA; bif.ready = 1'b0;
      issue(3'd1, 16'h5000, 8'h00, 1'b1);
      tick();  // T1
      bif.start = 1'b0;
      tick();  // T2
      tick();  // TW
      checks++; if (ctl !== C_RD) begin failures++; $display("FAIL rstmid_tw got=%b exp=%b", ctl, C_RD); end
      rst = 1'b1;
      tick();
      rst = 1'b0; bif.ready = 1'b1;
      checks++; if ({ctl, bif.rdata_out, bif.addr} !== {C_IDLE, 8'h00, 16'h0000}) begin failures++;
         $display("FAIL rstmid_idle got ctl=%b rdata=%h addr=%h exp ctl=%b rdata=00 addr=0000", ctl, bif.rdata_out, bif.addr, C_IDLE); end
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bif.done !== 1'b0 || bif.inc_req !== 1'b0) seen_done++;
      end
      checks++; if (seen_done !== 0) begin failures++; $display("FAIL rstmid_no_done got=%0d pulses exp=0", seen_done); end
   endtask

   task automatic test_ignored_start();
      bif.din = 8'h5C; bif.ready = 1'b1;
      issue(3'd1, 16'h6000, 8'h00, 1'b0);
      tick();  // T1
      bif.start = 1'b0;
      tick();  // T2: accept=0, this start must be ignored
      checks++; if (bif.accept !== 1'b0) begin failures++; $display("FAIL ign_accept got=%b exp=0", bif.accept); end
      issue(3'd2, 16'h7000, 8'h33, 1'b1);
      tick();  // T3
      bif.start = 1'b0;
      checks++; if ({ctl, bif.addr} !== {C_T3_RD, 16'h6000}) begin failures++;
         $display("FAIL ign_t3 got ctl=%b addr=%h exp ctl=%b addr=6000", ctl, bif.addr, C_T3_RD); end
      tick();
      checks++; if ({ctl, bif.rdata_out, bif.addr} !== {C_IDLE, 8'h5C, 16'h6000}) begin failures++;
         $display("FAIL ign_idle got ctl=%b rdata=%h addr=%h exp ctl=%b rdata=5c addr=6000", ctl, bif.rdata_out, bif.addr, C_IDLE); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      bif.start = 1'b0; bif.cycle_type = 3'd0; bif.addr_in = '0; bif.wdata_in = '0;
      bif.post_inc = 1'b0; bif.din = '0; bif.ready = 1'b1;
      test_reset();
      test_fetch();
      test_mem_wr_wait();
      test_io();
      test_back_to_back();
      test_reset_mid();
      test_ignored_start();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bus_cycle_sequencer.md
Name: bus_cycle_sequencer

Overview:
- Runs one i8080 machine cycle (T1, T2, optional TW wait states, T3) on the external memory/IO bus for each request from the control unit.
- Takes its address from the register array's register-pair read port.
- Returns read data for writeback into the register array.
- Requests the register-pair post-increment (PC/SP/WZ) at the architecturally correct T-state.

Parameters:
XLEN, 8, data width; address width is 2*XLEN.

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  request a machine cycle; accepted only when accept=1
cycle_type  in  3  0 FETCH, 1 MEM_RD, 2 MEM_WR, 3 STACK_RD, 4 STACK_WR, 5 IO_RD, 6 IO_WR, 7 INTA
addr_in  in  2*XLEN  address from the register array's register-pair data
wdata_in  in  XLEN  write data for MEM_WR/STACK_WR/IO_WR
post_inc  in  1  pulse inc_req during this cycle
accept  out  1  sequencer can take start this clock
done  out  1  one-cycle pulse in T3
rdata_out  out  XLEN  data captured in the last read-type T3; held until the next read
inc_req  out  1  one-cycle pulse in T2 when post_inc was latched
addr  out  2*XLEN  external address bus
dout  out  XLEN  external data out (status byte or write data)
dout_en  out  1  dout valid/driven
din  in  XLEN  external data in
sync  out  1  high in T1 only
dbin  out  1  read strobe
wr_n  out  1  active-low write strobe
ready  in  1  external ready; low inserts wait states

Behaviour:
- Reset is synchronous and active-high on rst; the clock is clk.
- On reset:
  - state = IDLE; accept=1, done=0, inc_req=0, sync=0, dbin=0, wr_n=1, dout_en=0.
  - addr=0, dout=0, rdata_out=0.
  - An rst asserted mid-cycle aborts the cycle: no done, no inc_req, strobes released the next edge.
- States: IDLE, T1, T2, TW, T3.
- Acceptance:
  - accept = (state==IDLE) || (state==T3).
  - start&&accept latches cycle_type, addr_in, wdata_in and post_inc into internal registers; next state = T1.
  - start in T3 gives back-to-back cycles with no IDLE gap.
  - start while accept=0 is ignored.
- Address:
  - addr comes from the latched address and is stable from T1 through T3.
  - IO_RD/IO_WR drive addr = {latched[XLEN-1:0], latched[XLEN-1:0]} (port number on both halves).
  - addr holds its value in IDLE.
- T1:
  - sync=1, dout_en=1, dout = status byte per type: FETCH A2, MEM_RD 82, MEM_WR 00, STACK_RD 86, STACK_WR 04, IO_RD 42, IO_WR 10, INTA 23 (hex).
  - Next state T2 unconditionally.
- T2:
  - Read types (FETCH, MEM_RD, STACK_RD, IO_RD, INTA): dbin=1, dout_en=0.
  - Write types: dout=latched wdata, dout_en=1, dbin=0.
  - inc_req=1 for exactly this one cycle if post_inc was latched.
  - ready=1 goes to T3; ready=0 goes to TW.
- TW:
  - Strobes/dout same as T2; inc_req=0.
  - Stays while ready=0; goes to T3 on the first ready=1 clock.
  - No wait limit.
- T3:
  - Read types: dbin=1; rdata_out <= din at the end of T3.
  - Write types: wr_n=0, dout=wdata, dout_en=1.
  - done=1.
  - Next state is T1 if start is accepted, otherwise IDLE.
- done and the rdata_out update refer to the same cycle; rdata_out is valid from the cycle after done.
- Write cycles never modify rdata_out.
- Strobe exclusivity: dbin and !wr_n are never both high; sync is never high together with dbin or !wr_n.
- Total latency start→done is 3 cycles plus the number of TW cycles.

Test Plan:
1. FETCH, addr_in=1234, post_inc=1, ready=1, din=3E → T1 shows addr=1234, sync=1, dout=A2; T2 shows inc_req=1, dbin=1; T3 shows done=1; rdata_out=3E the next cycle; 3 cycles total.
2. MEM_WR, addr_in=2000, wdata_in=5A, ready low for 2 cycles → T2, TW, TW, T3; wr_n=0 only in T3 with dout=5A; done on the 5th cycle; rdata_out unchanged.
3. IO_RD, addr_in=0707, din=C3 → T1 dout=42, addr=0707; rdata_out=C3. Then IO_WR, addr_in=0010 → addr=1010, T1 dout=10.
4. Back-to-back: STACK_RD then STACK_WR, with start held during the first T3 → second T1 directly follows T3 (no IDLE); status bytes 86 then 04.
5. rst asserted during TW of MEM_RD → next cycle IDLE, dbin=0, done never pulses, accept=1, rdata_out=0.
6. start with accept=0 (issued in T2) → ignored; the cycle completes normally with the original addr and type.
